// File: rtl/wb_regfile_if.sv
// Bus bundle between the memory stage, the W pipeline register/register file
// and the decode/forwarding logic.
interface wb_regfile_if;
  logic [3:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] m_valM;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic        halted;

  modport master (
    output M_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM,
           W_stall, W_bubble, d_srcA, d_srcB,
    input  W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
           d_rvalA, d_rvalB, halted
  );

  modport slave (
    input  M_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM,
           W_stall, W_bubble, d_srcA, d_srcB,
    output W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
           d_rvalA, d_rvalB, halted
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: W pipeline register, 15x64 register file and sticky halt flag.
// Optional macro RF_WRITE_THROUGH_EN makes reads return same-cycle write data.
module wb_regfile #(
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter logic [3:0]  RNONE    = 4'hF
) (
  input logic       clk,
  input logic       rst,
  wb_regfile_if.slave bus
);

  localparam logic [3:0] S_AOK   = 4'd1;
  localparam logic [3:0] S_HLT   = 4'd2;
  localparam logic [3:0] S_ADR   = 4'd3;
  localparam logic [3:0] S_INS   = 4'd4;
  localparam logic [3:0] LAST_ID = 4'd14;
  localparam int         NREGS   = 15;
  localparam int         RSP_ID  = 4;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_e;
    logic [63:0] val_m;
  } w_t;

  localparam w_t BUBBLE = '{stat: S_AOK, icode: 4'h1, dst_e: RNONE, dst_m: RNONE,
                            val_e: 64'h0, val_m: 64'h0};

  w_t          w_q;
  w_t          m_in;
  logic [63:0] regs [NREGS];
  logic        halted_q;
  logic        wr_en;
  logic        wr_e;
  logic        wr_m;
  logic [3:0]  src  [2];
  logic [63:0] rval [2];

  assign m_in = '{stat: bus.M_stat, icode: bus.M_icode, dst_e: bus.M_dstE,
                  dst_m: bus.M_dstM, val_e: bus.M_valE, val_m: bus.m_valM};

  // Stall outranks bubble; reset outranks both.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= BUBBLE;
    end else if (!bus.W_stall) begin
      w_q <= bus.W_bubble ? BUBBLE : m_in;
    end
  end

  assign wr_en = (w_q.stat == S_AOK) && !halted_q;
  assign wr_e  = wr_en && (w_q.dst_e != RNONE) && (w_q.dst_e <= LAST_ID);
  assign wr_m  = wr_en && (w_q.dst_m != RNONE) && (w_q.dst_m <= LAST_ID);

  // The M write comes second so it wins when both ports target one ID.
  // NOTE: the register file is reset explicitly because %rsp must load RSP_INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == RSP_ID) ? RSP_INIT : 64'h0;
      end
    end else begin
      if (wr_e) regs[w_q.dst_e] <= w_q.val_e;
      if (wr_m) regs[w_q.dst_m] <= w_q.val_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (w_q.stat == S_HLT || w_q.stat == S_ADR || w_q.stat == S_INS) begin
      halted_q <= 1'b1;
    end
  end

  assign src[0] = bus.d_srcA;
  assign src[1] = bus.d_srcB;

  // NOTE: rval gets a default before any branch so no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rval[p] = 64'h0;
      if (src[p] != RNONE && src[p] <= LAST_ID) begin
        rval[p] = regs[src[p]];
`ifdef RF_WRITE_THROUGH_EN
        if (wr_m && w_q.dst_m == src[p]) begin
          rval[p] = w_q.val_m;
        end else if (wr_e && w_q.dst_e == src[p]) begin
          rval[p] = w_q.val_e;
        end
`endif
      end
    end
  end

  assign bus.d_rvalA = rval[0];
  assign bus.d_rvalB = rval[1];
  assign bus.W_stat  = w_q.stat;
  assign bus.W_icode = w_q.icode;
  assign bus.W_dstE  = w_q.dst_e;
  assign bus.W_dstM  = w_q.dst_m;
  assign bus.W_valE  = w_q.val_e;
  assign bus.W_valM  = w_q.val_m;
  assign bus.halted  = halted_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against a behavioural model of the write-back rules.
module tb_wb_regfile;

  localparam logic [63:0] RSP = 64'h200;
  localparam logic [3:0]  RN  = 4'hF;

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_e;
    logic [63:0] val_m;
  } wf_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [63:0] m_regs [15];
  wf_t         m_w;
  logic        m_halted;

  wb_regfile_if bus();

  wb_regfile #(.RSP_INIT(RSP), .RNONE(RN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic wf_t bubble();
    wf_t b;
    b = '{stat: 4'd1, icode: 4'd1, dst_e: RN, dst_m: RN, val_e: 64'h0, val_m: 64'h0};
    return b;
  endfunction

  // Reference: apply one clock edge using the current inputs.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
      m_regs[4] = RSP;
      m_w       = bubble();
      m_halted  = 1'b0;
    end else begin
      if (m_w.stat == 4'd1 && !m_halted) begin
        if (m_w.dst_e != RN) m_regs[m_w.dst_e] = m_w.val_e;
        if (m_w.dst_m != RN) m_regs[m_w.dst_m] = m_w.val_m;
      end
      if (m_w.stat == 4'd2 || m_w.stat == 4'd3 || m_w.stat == 4'd4) m_halted = 1'b1;
      if (!bus.W_stall) begin
        if (bus.W_bubble) m_w = bubble();
        else m_w = '{stat: bus.M_stat, icode: bus.M_icode, dst_e: bus.M_dstE,
                     dst_m: bus.M_dstM, val_e: bus.M_valE, val_m: bus.m_valM};
      end
    end
  endtask

  function automatic logic [63:0] model_read(input logic [3:0] id);
    logic [63:0] v;
    if (id == RN) return 64'h0;
    v = m_regs[id];
`ifdef RF_WRITE_THROUGH_EN
    if (m_w.stat == 4'd1 && !m_halted) begin
      if (m_w.dst_m == id) v = m_w.val_m;
      else if (m_w.dst_e == id) v = m_w.val_e;
    end
`endif
    return v;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [3:0] stat, input logic [3:0] icode,
                       input logic [3:0] dste, input logic [63:0] vale,
                       input logic [3:0] dstm, input logic [63:0] valm);
    bus.M_stat  = stat;
    bus.M_icode = icode;
    bus.M_dstE  = dste;
    bus.M_valE  = vale;
    bus.M_dstM  = dstm;
    bus.m_valM  = valm;
  endtask

  task automatic idle();
    set_m(4'd1, 4'd1, RN, 64'h0, RN, 64'h0);
    bus.W_stall  = 1'b0;
    bus.W_bubble = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.d_srcA = 4'd0;
    bus.d_srcB = 4'd0;
    tick();
    rst = 1'b0;
    bus.d_srcA = 4'd4;
    bus.d_srcB = 4'd3;
    #1;
    checks++;
    if (bus.d_rvalA !== 64'h200) begin
      failures++; $display("FAIL reset_rsp: got %h expected %h", bus.d_rvalA, 64'h200);
    end
    checks++;
    if (bus.d_rvalB !== 64'h0) begin
      failures++; $display("FAIL reset_reg3: got %h expected 0", bus.d_rvalB);
    end
    checks++;
    if (bus.halted !== 1'b0) begin
      failures++; $display("FAIL reset_halted: got %b expected 0", bus.halted);
    end
    checks++;
    if (bus.W_icode !== 4'd1 || bus.W_stat !== 4'd1 || bus.W_dstE !== RN || bus.W_dstM !== RN) begin
      failures++;
      $display("FAIL reset_w: got icode=%h stat=%h dstE=%h dstM=%h expected 1 1 f f",
               bus.W_icode, bus.W_stat, bus.W_dstE, bus.W_dstM);
    end
  endtask

  task automatic test_basic_write();
    logic [63:0] exp_pre;
    set_m(4'd1, 4'd3, 4'd2, 64'h55, RN, 64'h0);
    tick();
    idle();
    bus.d_srcA = 4'd2;
    #1;
    checks++;
    if (bus.W_valE !== 64'h55 || bus.W_dstE !== 4'd2) begin
      failures++; $display("FAIL basic_w: got valE=%h dstE=%h expected 55 2", bus.W_valE, bus.W_dstE);
    end
`ifdef RF_WRITE_THROUGH_EN
    exp_pre = 64'h55;
`else
    exp_pre = 64'h0;
`endif
    checks++;
    if (bus.d_rvalA !== exp_pre) begin
      failures++; $display("FAIL basic_pre: got %h expected %h", bus.d_rvalA, exp_pre);
    end
    tick();
    checks++;
    if (bus.d_rvalA !== 64'h55) begin
      failures++; $display("FAIL basic_reg2: got %h expected 55", bus.d_rvalA);
    end
  endtask

  task automatic test_port_priority();
    logic [63:0] exp_pre;
    set_m(4'd1, 4'd5, 4'd4, 64'h1F0, 4'd4, 64'hABC);
    tick();
    idle();
    bus.d_srcA = 4'd4;
    #1;
`ifdef RF_WRITE_THROUGH_EN
    exp_pre = 64'hABC;
`else
    exp_pre = 64'h200;
`endif
    checks++;
    if (bus.d_rvalA !== exp_pre) begin
      failures++; $display("FAIL prio_pre: got %h expected %h", bus.d_rvalA, exp_pre);
    end
    tick();
    checks++;
    if (bus.d_rvalA !== 64'hABC) begin
      failures++; $display("FAIL prio_reg4: got %h expected abc", bus.d_rvalA);
    end
  endtask

  task automatic test_stall_bubble();
    set_m(4'd1, 4'd5, 4'd6, 64'h77, RN, 64'h0);
    tick();
    set_m(4'd1, 4'd6, 4'd7, 64'h99, 4'd8, 64'h33);
    bus.W_stall  = 1'b1;
    bus.W_bubble = 1'b1;
    tick();
    checks++;
    if (bus.W_dstE !== 4'd6 || bus.W_valE !== 64'h77 || bus.W_icode !== 4'd5) begin
      failures++;
      $display("FAIL stall_hold: got dstE=%h valE=%h icode=%h expected 6 77 5",
               bus.W_dstE, bus.W_valE, bus.W_icode);
    end
    bus.W_stall = 1'b0;
    tick();
    checks++;
    if (bus.W_dstE !== RN || bus.W_stat !== 4'd1 || bus.W_valE !== 64'h0) begin
      failures++;
      $display("FAIL bubble_load: got dstE=%h stat=%h valE=%h expected f 1 0",
               bus.W_dstE, bus.W_stat, bus.W_valE);
    end
    idle();
    bus.d_srcA = 4'd6;
    bus.d_srcB = 4'd7;
    #1;
    checks++;
    if (bus.d_rvalA !== 64'h77 || bus.d_rvalB !== 64'h0) begin
      failures++;
      $display("FAIL stall_regs: got r6=%h r7=%h expected 77 0", bus.d_rvalA, bus.d_rvalB);
    end
  endtask

  task automatic test_reset_inflight();
    set_m(4'd1, 4'd3, 4'd5, 64'h9, RN, 64'h0);
    tick();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    bus.d_srcA = 4'd5;
    bus.d_srcB = 4'd4;
    #1;
    checks++;
    if (bus.d_rvalA !== 64'h0) begin
      failures++; $display("FAIL rst_inflight_reg5: got %h expected 0", bus.d_rvalA);
    end
    checks++;
    if (bus.d_rvalB !== 64'h200 || bus.W_dstE !== RN) begin
      failures++;
      $display("FAIL rst_inflight_state: got r4=%h dstE=%h expected 200 f", bus.d_rvalB, bus.W_dstE);
    end
  endtask

  task automatic test_halt();
    set_m(4'd2, 4'd0, RN, 64'h0, RN, 64'h0);
    tick();
    set_m(4'd1, 4'd3, 4'd1, 64'h7, RN, 64'h0);
    tick();
    checks++;
    if (bus.halted !== 1'b1) begin
      failures++; $display("FAIL halt_set: got %b expected 1", bus.halted);
    end
    idle();
    bus.d_srcA = 4'd1;
    tick();
    checks++;
    if (bus.d_rvalA !== 64'h0 || bus.halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_nowrite: got r1=%h halted=%b expected 0 1", bus.d_rvalA, bus.halted);
    end
  endtask

  task automatic test_random();
    int r;
    logic [63:0] ea;
    logic [63:0] eb;
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      set_m((r < 3) ? 4'($urandom_range(2, 4)) : ((r < 5) ? 4'd0 : 4'd1),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, 4'($urandom_range(0, 15)), {$urandom, $urandom});
      bus.W_stall  = ($urandom_range(0, 4) == 0);
      bus.W_bubble = ($urandom_range(0, 5) == 0);
      bus.d_srcA   = 4'($urandom_range(0, 15));
      bus.d_srcB   = 4'($urandom_range(0, 15));
      rst          = ($urandom_range(0, 29) == 0);
      #1;
      ea = model_read(bus.d_srcA);
      eb = model_read(bus.d_srcB);
      checks++;
      if (bus.d_rvalA !== ea || bus.d_rvalB !== eb) begin
        failures++;
        $display("FAIL rand_read[%0d]: got A=%h B=%h expected A=%h B=%h",
                 n, bus.d_rvalA, bus.d_rvalB, ea, eb);
      end
      checks++;
      if (bus.W_stat !== m_w.stat || bus.W_icode !== m_w.icode || bus.W_dstE !== m_w.dst_e ||
          bus.W_dstM !== m_w.dst_m || bus.W_valE !== m_w.val_e || bus.W_valM !== m_w.val_m) begin
        failures++;
        $display("FAIL rand_w[%0d]: got stat=%h dstE=%h dstM=%h valE=%h expected %h %h %h %h",
                 n, bus.W_stat, bus.W_dstE, bus.W_dstM, bus.W_valE,
                 m_w.stat, m_w.dst_e, m_w.dst_m, m_w.val_e);
      end
      checks++;
      if (bus.halted !== m_halted) begin
        failures++; $display("FAIL rand_halted[%0d]: got %b expected %b", n, bus.halted, m_halted);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_port_priority();
    test_stall_bubble();
    test_reset_inflight();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter RSP_INIT, default 64'h0, is the value loaded into register 4 (%rsp) at reset.
REQ-002 Parameter RNONE, default 4'hF, is the register ID meaning "no register".
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 M_stat, M_icode  input  4,4  memory-stage status and icode captured into W.
REQ-006 M_valE, m_valM  input  64,64  ALU result and memory read data captured into W.
REQ-007 M_dstE, M_dstM  input  4,4  destination register IDs captured into W.
REQ-008 W_stall, W_bubble  input  1,1  pipeline control for the W register.
REQ-009 d_srcA, d_srcB  input  4,4  decode-stage read addresses.
REQ-010 W_stat, W_icode, W_dstE, W_dstM  output  4 each  registered W-stage fields, driven to the forwarding logic.
REQ-011 W_valE, W_valM  output  64,64  registered W-stage values, driven to the forwarding logic.
REQ-012 d_rvalA, d_rvalB  output  64,64  register-file read data.
REQ-013 halted  output  1  sticky flag indicating that an abnormal status has retired.

Function
REQ-014 Status encodings: AOK=1, HLT=2, ADR=3, INS=4.
REQ-015 W register update at each edge with rst low:
- W_stall=1: W holds its contents.
- W_stall=0, W_bubble=1: W loads the bubble.
- Otherwise: W loads the M inputs.
- W_stall=1 and W_bubble=1 together: W_stall wins.
REQ-016 Bubble contents: icode 4'h1, stat AOK, dstE=dstM=RNONE, valE=valM=0.
REQ-017 Register file: 15 x 64-bit entries, IDs 0..14; ID RNONE is never written.
REQ-018 At each edge, when W_stat==AOK and halted==0, write W_valE to W_dstE and W_valM to W_dstM; a port whose ID is RNONE does not write.
REQ-019 W_dstE==W_dstM!=RNONE at the same edge: W_valM is written (M port priority).
REQ-020 Writes use the W contents present before the edge, so total latency is one cycle in W plus the write edge.
REQ-021 A repeated write while W_stall=1 is permitted and is idempotent.
REQ-022 d_rvalA and d_rvalB are combinational reads; a source ID of RNONE reads 64'h0.
REQ-023 halted sets at the first edge where W_stat is HLT, ADR or INS, and clears only on rst.
REQ-024 While halted=1, no register write occurs, even if W_stat later returns to AOK.

Reset
REQ-025 On a rst edge:
- All registers clear to 0, except register 4, which loads RSP_INIT.
- W loads the bubble (W_stat=1, W_icode=1, W_dstE=W_dstM=4'hF, W_valE=W_valM=0).
- halted clears to 0.
REQ-026 rst takes priority over W_stall, W_bubble and any pending write; rst asserted mid-operation discards the in-flight W instruction without writing it.

Configuration
REQ-027 Macro RF_WRITE_THROUGH_EN defined: when a write from REQ-018/019 targets the ID being read, the read port returns the value being written in the same cycle, applying the same M-port priority.
REQ-028 Macro RF_WRITE_THROUGH_EN undefined: reads return the pre-edge register contents, and the forwarding logic supplies same-cycle values.

Verification
REQ-029 Reset with RSP_INIT=64'h200 -> reading srcA=4 gives 64'h200, srcB=3 gives 0, halted=0, W_icode=1.
REQ-030 M: stat=1, dstE=2, valE=64'h55, dstM=F, then one idle edge -> W_valE=64'h55 after edge 1; reg2=64'h55 after edge 2.
REQ-031 dstE=dstM=4, valE=64'h1F0, valM=64'hABC -> reg4=64'hABC; with the macro on, srcA=4 shows 64'hABC during the write cycle, and with it off shows the old value.
REQ-032 An HLT instruction enters W followed by an AOK write to reg1 of 64'h7 -> halted=1 and reg1 remains unchanged.
REQ-033 W_stall=1 and W_bubble=1 with new M data -> W unchanged; next edge with only W_bubble=1 -> W_dstE=F, W_stat=1.
REQ-034 rst asserted while W holds a valid write to reg5 of 64'h9 -> reg5 remains 0.
